bird_motion: RTL and testbench
==============================

# bird_motion

Per-frame vertical motion engine for the player sprite. Sits directly upstream of the VGA controller: consumes the display's end-of-frame pulse and a raw flap button, integrates gravity and flap impulses once per frame, and drives the sprite's top-left Y coordinate plus game-state flags the renderer uses to place and colour the bird.

## Interface
- Y_START, 200: bird Y after reset and on restart.
- Y_MIN, 0: ceiling Y bound.
- Y_MAX, 430: floor Y bound (480 minus 50-pixel sprite).
- GRAVITY, 1: velocity increment per frame.
- FLAP_SPEED, 8: upward speed set by a flap (applied as −FLAP_SPEED).
- MAX_FALL, 10: downward velocity saturation.
- VEL_WIDTH, 8: signed velocity width.

- clk  in  1  100 MHz system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- frame_tick  in  1  end-of-frame level from the timing generator (screenEnd); same clock family, no synchroniser.
- flap  in  1  raw button, asynchronous to clk.
- bird_y  out  9  sprite top-left Y.
- alive  out  1  high in FLYING.
- state  out  2  current FSM state.
- frame_update  out  1  one-cycle pulse on the cycle bird_y/state update.

## Operation
- frame_tick rising edge detected with one register → internal tick (one clk).
- flap: 2-FF synchroniser then rising-edge detect; edge sets flap_pending. Multiple edges before a tick collapse to one. Pending cleared on every tick (consumed or not). Edge and tick on same cycle: edge counts for that tick.
- FSM states: IDLE (0), FLYING (1), DEAD (2); 3 unreachable, decodes as IDLE.
- IDLE: bird_y = Y_START, vel = 0. Tick with pending → FLYING, vel = −FLAP_SPEED, bird_y = Y_START − FLAP_SPEED same tick.
- FLYING, per tick: vel_new = pending ? −FLAP_SPEED : min(vel + GRAVITY, MAX_FALL); y_next = bird_y + vel_new in 11-bit signed.
  - y_next ≥ Y_MAX → bird_y = Y_MAX, vel = 0, DEAD.
  - y_next < Y_MIN → see Configuration.
  - else bird_y = y_next, vel = vel_new.
- DEAD: bird_y, vel held. Tick with pending → IDLE, bird_y = Y_START, vel = 0.
- No tick: nothing changes except pending capture.

## Timing
- Reset values: bird_y = Y_START, vel = 0, state = IDLE, alive = 0, frame_update = 0, flap_pending = 0, sync/edge registers 0.
- Update latency: registered outputs change on the clk edge after the one sampling frame_tick high (1 clk after tick edge detect); frame_update high that same cycle only.
- Flap latency: button edge to pending = 3 clk; effect visible at next tick.
- alive is registered decode of state, updates with state.
- Reset mid-frame or mid-update: outputs return to reset values asynchronously; pending flap discarded.

## Configuration
- BIRD_CEILING_KILL_EN defined: y_next < Y_MIN → bird_y = Y_MIN, vel = 0, DEAD.
- Undefined: y_next < Y_MIN → bird_y = Y_MIN, vel = 0, remain FLYING.

## Structure
- bird_pkg: state encoding constants (IDLE/FLYING/DEAD), default Y_START/Y_MIN/Y_MAX/GRAVITY/FLAP_SPEED/MAX_FALL, VEL_WIDTH.
- One sub-module: sync_edge (2-FF synchroniser + rising-edge pulse, async active-high reset), instantiated for flap.

## Test plan
- Reset, then 5 ticks no flap → bird_y = 200, state = 0, alive = 0 throughout; frame_update pulses 5 times.
- Flap in IDLE then 3 ticks → state 1, bird_y 192, 185, 179 (vel −8, −7, −6).
- Continue without flap → vel saturates at 10; bird_y clamps to 430, state 2, alive 0; further ticks hold 430; flap+tick → IDLE, bird_y 200.
- Three flap presses between two ticks during FLYING → exactly one −8 impulse; following tick applies gravity (vel −7).
- Flap every tick from IDLE until y_next < 0 → with BIRD_CEILING_KILL_EN: bird_y 0, state 2; without: bird_y 0, state 1, next non-flap tick bird_y 1.
- Assert reset between clock edges during FLYING at bird_y 150 → bird_y 200, state 0, alive 0 before next clk edge; flap pressed during reset ignored.

Source files
------------

// File: rtl/bird_pkg.sv
// bird_pkg: shared constants and types for the bird motion engine.
//   - bird_state_t : FSM encoding (IDLE=0, FLYING=1, DEAD=2; 3 is unused)
//   - Y_START/Y_MIN/Y_MAX : vertical positions in pixels (sprite top-left)
//   - GRAVITY/FLAP_SPEED/MAX_FALL : per-frame velocity rules
//   - VEL_WIDTH / vel_t : signed velocity register width and type
package bird_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLYING = 2'd1,
    ST_DEAD   = 2'd2
  } bird_state_t;

  localparam int Y_START    = 200;
  localparam int Y_MIN      = 0;
  localparam int Y_MAX      = 430;  // 480 lines minus the 50-pixel sprite
  localparam int GRAVITY    = 1;
  localparam int FLAP_SPEED = 8;
  localparam int MAX_FALL   = 10;
  localparam int VEL_WIDTH  = 8;

  typedef logic signed [VEL_WIDTH-1:0] vel_t;

endpackage

// File: rtl/sync_edge.sv
// sync_edge: two-flop synchroniser for an asynchronous level, followed by a
// rising-edge detector.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-high reset, clears all three flops
//   d     - asynchronous input level
//   pulse - one-clk pulse for each synchronised rising edge of d
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/bird_motion.sv
// bird_motion: per-frame vertical motion engine for the player sprite.
// Once per frame (rising edge of frame_tick) it applies gravity or a flap
// impulse, clamps to the floor/ceiling and advances the game FSM.
// Ports:
//   clk          - system clock, all state on rising edge
//   reset        - asynchronous active-high reset
//   frame_tick   - end-of-frame level from the display timing generator
//   flap         - raw flap button (asynchronous)
//   bird_y       - sprite top-left Y (9 bits)
//   alive        - high while FLYING
//   state        - current FSM state (IDLE=0, FLYING=1, DEAD=2)
//   frame_update - one-clk pulse on the cycle bird_y/state update
// Handshake: there is no valid/ready pair; frame_update is a pure strobe that
// marks the cycle on which bird_y/state/alive carry a new frame's values.
// Build option: define BIRD_CEILING_KILL_EN to make hitting the ceiling fatal;
// by default the bird is pinned at Y_MIN and keeps flying.
module bird_motion
  import bird_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       flap,
  output logic [8:0] bird_y,
  output logic       alive,
  output logic [1:0] state,
  output logic       frame_update
);

  localparam logic signed [VEL_WIDTH:0] MAX_FALL_X = (VEL_WIDTH+1)'(MAX_FALL);
  localparam logic signed [VEL_WIDTH:0] GRAVITY_X  = (VEL_WIDTH+1)'(GRAVITY);
  localparam logic signed [10:0]        Y_MAX_S    = 11'(Y_MAX);
  localparam logic signed [10:0]        Y_MIN_S    = 11'(Y_MIN);
  localparam vel_t                      VEL_FLAP   = vel_t'(-FLAP_SPEED);

  bird_state_t st_q;
  vel_t        vel_q;
  logic        ft_q;
  logic        tick;
  logic        flap_pulse;
  logic        flap_pending;
  logic        flap_eff;

  logic signed [VEL_WIDTH:0] vel_inc;
  vel_t                      vel_new;
  logic signed [10:0]        y_next;

  sync_edge u_flap_sync (
    .clk   (clk),
    .reset (reset),
    .d     (flap),
    .pulse (flap_pulse)
  );

  // A flap edge arriving on the tick cycle still belongs to this frame.
  assign flap_eff = flap_pending | flap_pulse;
  assign state    = st_q;

  always_comb begin
    vel_inc = {vel_q[VEL_WIDTH-1], vel_q} + GRAVITY_X;
    if (flap_eff) begin
      vel_new = VEL_FLAP;
    end else if (vel_inc > MAX_FALL_X) begin
      vel_new = vel_t'(MAX_FALL);
    end else begin
      vel_new = vel_inc[VEL_WIDTH-1:0];
    end
    // 11-bit signed sum so both overshoots (below 0, past the floor) are visible.
    y_next = $signed({2'b00, bird_y}) + {{(11-VEL_WIDTH){vel_new[VEL_WIDTH-1]}}, vel_new};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ft_q         <= 1'b0;
      tick         <= 1'b0;
      frame_update <= 1'b0;
      flap_pending <= 1'b0;
      st_q         <= ST_IDLE;
      alive        <= 1'b0;
      bird_y       <= 9'(Y_START);
      vel_q        <= '0;
    end else begin
      ft_q         <= frame_tick;
      tick         <= frame_tick & ~ft_q;
      frame_update <= tick;

      // Pending is consumed by every tick, whether or not the state used it.
      if (tick) begin
        flap_pending <= 1'b0;
      end else if (flap_pulse) begin
        flap_pending <= 1'b1;
      end

      if (tick) begin
        case (st_q)
          ST_FLYING: begin
            if (y_next >= Y_MAX_S) begin
              bird_y <= 9'(Y_MAX);
              vel_q  <= '0;
              st_q   <= ST_DEAD;
              alive  <= 1'b0;
            end else if (y_next < Y_MIN_S) begin
              bird_y <= 9'(Y_MIN);
              vel_q  <= '0;
`ifdef BIRD_CEILING_KILL_EN
              st_q   <= ST_DEAD;
              alive  <= 1'b0;
`else
              st_q   <= ST_FLYING;
              alive  <= 1'b1;
`endif
            end else begin
              bird_y <= y_next[8:0];
              vel_q  <= vel_new;
            end
          end
          ST_DEAD: begin
            if (flap_eff) begin
              st_q   <= ST_IDLE;
              alive  <= 1'b0;
              bird_y <= 9'(Y_START);
              vel_q  <= '0;
            end
          end
          default: begin
            // IDLE, and the unused encoding 3 which behaves as IDLE.
            if (flap_eff) begin
              st_q   <= ST_FLYING;
              alive  <= 1'b1;
              bird_y <= 9'(Y_START - FLAP_SPEED);
              vel_q  <= VEL_FLAP;
            end else begin
              st_q   <= ST_IDLE;
              alive  <= 1'b0;
              bird_y <= 9'(Y_START);
              vel_q  <= '0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bird_motion.sv
module tb_bird_motion;

  logic       clk;
  logic       reset;
  logic       frame_tick;
  logic       flap;
  logic [8:0] bird_y;
  logic       alive;
  logic [1:0] state;
  logic       frame_update;

  int total;
  int bad;
  int fu_count;

  logic [10:0] exp_q[$];

  bird_motion dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .flap         (flap),
    .bird_y       (bird_y),
    .alive        (alive),
    .state        (state),
    .frame_update (frame_update)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural reference model ----------------
  // Motion rules on plain integers, one update per frame.  The timing side
  // only tracks when a frame update lands and which flap presses it sees:
  // a press sampled at edge m is seen by the first update at edge >= m+2,
  // and an update lands one edge after frame_tick is first sampled high.
  int m_y, m_v, m_st;
  bit m_fu, m_pend, m_upd_next, m_ft_prev;
  bit fl1, fl2, fl3;

  task automatic model_frame(input bit pend);
    int vn, yn;
    case (m_st)
      1: begin
        vn = pend ? -8 : ((m_v + 1 > 10) ? 10 : m_v + 1);
        yn = m_y + vn;
        if (yn >= 430) begin
          m_y = 430; m_v = 0; m_st = 2;
        end else if (yn < 0) begin
          m_y = 0; m_v = 0;
`ifdef BIRD_CEILING_KILL_EN
          m_st = 2;
`endif
        end else begin
          m_y = yn; m_v = vn;
        end
      end
      2: if (pend) begin m_st = 0; m_y = 200; m_v = 0; end
      default: if (pend) begin m_st = 1; m_v = -8; m_y = 192; end
    endcase
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_y = 200; m_v = 0; m_st = 0; m_fu = 0; m_pend = 0;
      m_upd_next = 0; m_ft_prev = 0; fl1 = 0; fl2 = 0; fl3 = 0;
      exp_q.delete();
    end else begin
      bit press_seen;
      press_seen = fl2 & ~fl3;
      m_fu = m_upd_next;
      if (m_upd_next) begin
        model_frame(m_pend | press_seen);
        m_pend = 0;
        exp_q.push_back({m_st[1:0], m_y[8:0]});
      end else begin
        m_pend = m_pend | press_seen;
      end
      m_upd_next = frame_tick & ~m_ft_prev;
      m_ft_prev  = frame_tick;
      fl3 = fl2; fl2 = fl1; fl1 = flap;
    end
  end

  // ---------------- scoreboard / compare ----------------
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check("bird_y", int'(bird_y), m_y);
      check("state", int'(state), m_st);
      check("alive", int'(alive), int'(m_st == 1));
      check("frame_update", int'(frame_update), int'(m_fu));
      if (frame_update) begin
        fu_count++;
        if (exp_q.size() == 0) begin
          check("update_queue_empty", 1, 0);
        end else begin
          logic [10:0] e;
          e = exp_q.pop_front();
          check("update_record", int'({state, bird_y}), int'(e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One frame: frame_tick high for 2 cycles then low for gap cycles.
  // fa >= 0 raises flap for one cycle at that cycle offset inside the frame.
  task automatic do_tick(input int gap, input int fa);
    for (int i = 0; i < 2 + gap; i++) begin
      @(negedge clk);
      frame_tick = (i < 2);
      flap       = (i == fa);
    end
    @(negedge clk);
    frame_tick = 1'b0;
    flap       = 1'b0;
  endtask

  task automatic press(input int hold);
    @(negedge clk);
    flap = 1'b1;
    repeat (hold - 1) @(negedge clk);
    @(negedge clk);
    flap = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int fu_start;
    int n;
    total = 0; bad = 0; fu_count = 0;
    reset = 1'b1; frame_tick = 1'b0; flap = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_y", int'(bird_y), 200);
    check("reset_state", int'(state), 0);
    check("reset_alive", int'(alive), 0);
    check("reset_fu", int'(frame_update), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Idle frames without flap.
    fu_start = fu_count;
    for (int i = 0; i < 5; i++) do_tick(4, -1);
    check("idle_y", int'(bird_y), 200);
    check("idle_state", int'(state), 0);
    check("idle_fu_pulses", fu_count - fu_start, 5);

    // Start and first three frames.
    press(1);
    do_tick(4, -1);
    check("start_y0", int'(bird_y), 192);
    check("start_state", int'(state), 1);
    check("start_alive", int'(alive), 1);
    do_tick(4, -1);
    check("start_y1", int'(bird_y), 185);
    do_tick(4, -1);
    check("start_y2", int'(bird_y), 179);

    // Fall to the floor.
    n = 0;
    while (state != 2 && n < 40) begin
      do_tick(3, -1);
      n++;
    end
    check("floor_reached_in_budget", int'(n < 40), 1);
    check("floor_y", int'(bird_y), 430);
    check("floor_alive", int'(alive), 0);
    do_tick(3, -1);
    do_tick(3, -1);
    check("dead_hold_y", int'(bird_y), 430);
    check("dead_hold_state", int'(state), 2);
    press(2);
    do_tick(3, -1);
    check("restart_y", int'(bird_y), 200);
    check("restart_state", int'(state), 0);

    // Several presses in one frame collapse to one impulse.
    press(1);
    do_tick(3, -1);
    check("multi_y0", int'(bird_y), 192);
    press(1); press(2); press(1);
    do_tick(3, -1);
    check("multi_y1", int'(bird_y), 184);
    do_tick(3, -1);
    check("multi_y2", int'(bird_y), 177);

    // Flap every frame up into the ceiling.
    do_reset();
    for (int i = 0; i < 25; i++) begin
      press(1);
      do_tick(3, -1);
    end
    check("ceiling_y_reach", int'(bird_y), 0);
    check("ceiling_state_reach", int'(state), 1);
    press(1);
    do_tick(3, -1);
    check("ceiling_y", int'(bird_y), 0);
`ifdef BIRD_CEILING_KILL_EN
    check("ceiling_state_kill", int'(state), 2);
`else
    check("ceiling_state_fly", int'(state), 1);
    do_tick(3, -1);
    check("ceiling_after_y", int'(bird_y), 1);
`endif

    // Asynchronous reset mid-flight at bird_y 150.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      press(1);
      do_tick(3, -1);
    end
    for (int i = 0; i < 3; i++) do_tick(3, -1);
    check("pre_reset_y", int'(bird_y), 150);
    @(posedge clk);
    #3;
    reset = 1'b1;
    flap  = 1'b1;
    #1;
    check("async_reset_y", int'(bird_y), 200);
    check("async_reset_state", int'(state), 0);
    check("async_reset_alive", int'(alive), 0);
    @(negedge clk);
    flap = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    do_tick(3, -1);
    check("reset_flap_ignored", int'(state), 0);

    // Randomised play against the model.
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      if ($urandom_range(0, 99) < 30) begin
        int k;
        k = $urandom_range(1, 3);
        for (int j = 0; j < k; j++) press($urandom_range(1, 3));
      end
      if ($urandom_range(0, 99) < 20)
        do_tick($urandom_range(3, 6), $urandom_range(0, 3));
      else
        do_tick($urandom_range(3, 6), -1);
    end
    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
